// File: rtl/preadd_mac_if.sv
// Term-stream and result-stream bundle for the pre-adder MAC packet sequencer.
// The master side produces terms and consumes results; the slave side is the sequencer.
interface preadd_mac_if #(
    parameter int AW   = 18,
    parameter int BW   = 18,
    parameter int CNTW = 8
);
    localparam int MW = AW + 1 + BW;

    logic                 s_valid;
    logic                 s_ready;
    logic signed [AW-1:0] s_a;
    logic signed [AW-1:0] s_d;
    logic signed [BW-1:0] s_b;
    logic                 s_last;
    logic signed [MW-1:0] s_bias;

    logic                 m_valid;
    logic                 m_ready;
    logic signed [MW:0]   m_data;
    logic [CNTW-1:0]      m_terms;

    modport master (
        output s_valid, s_a, s_d, s_b, s_last, s_bias, m_ready,
        input  s_ready, m_valid, m_data, m_terms
    );

    modport slave (
        input  s_valid, s_a, s_d, s_b, s_last, s_bias, m_ready,
        output s_ready, m_valid, m_data, m_terms
    );
endinterface

// File: rtl/preadd_mac_seq.sv
// Packet sequencer around a pipelined pre-adder MAC: accumulates bias + sum((a+/-d)*b)
// per packet through the MAC cascade loop and queues each packet result in a 2-entry FIFO.

module cpreadder_mac_unit #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int ADDSUB = 0,
    parameter int AREG   = 2,
    parameter int BREG   = 3,
    parameter int MW     = AW + 1 + BW
) (
    input  logic                 clk,
    input  logic signed [AW-1:0] ain,
    input  logic signed [AW-1:0] din,
    input  logic signed [BW-1:0] bin,
    input  logic signed [MW:0]   cin,
    output logic signed [MW:0]   pout
);
    // b is delayed one stage more than a/d so it meets the registered pre-add result
    logic signed [AW-1:0] a_pipe_reg [0:AREG-1];
    logic signed [AW-1:0] d_pipe_reg [0:AREG-1];
    logic signed [BW-1:0] b_pipe_reg [0:BREG-1];
    logic signed [AW:0]   ad_reg;
    logic signed [AW:0]   ad_next;
    logic signed [MW-1:0] ad_ext;
    logic signed [MW-1:0] b_ext;
    logic signed [MW-1:0] mult_reg;
    logic signed [MW-1:0] m_reg;
    logic signed [MW:0]   pout_reg;

    generate
        if (ADDSUB != 0) begin : g_sub
            assign ad_next = {a_pipe_reg[AREG-1][AW-1], a_pipe_reg[AREG-1]}
                           - {d_pipe_reg[AREG-1][AW-1], d_pipe_reg[AREG-1]};
        end else begin : g_add
            assign ad_next = {a_pipe_reg[AREG-1][AW-1], a_pipe_reg[AREG-1]}
                           + {d_pipe_reg[AREG-1][AW-1], d_pipe_reg[AREG-1]};
        end
    endgenerate

    assign ad_ext = {{BW{ad_reg[AW]}}, ad_reg};
    assign b_ext  = {{(AW+1){b_pipe_reg[BREG-1][BW-1]}}, b_pipe_reg[BREG-1]};

    always_ff @(posedge clk) begin
        a_pipe_reg[0] <= ain;
        d_pipe_reg[0] <= din;
        b_pipe_reg[0] <= bin;
        for (int i = 1; i < AREG; i++) begin
            a_pipe_reg[i] <= a_pipe_reg[i-1];
            d_pipe_reg[i] <= d_pipe_reg[i-1];
        end
        for (int i = 1; i < BREG; i++) begin
            b_pipe_reg[i] <= b_pipe_reg[i-1];
        end
        ad_reg   <= ad_next;
        mult_reg <= ad_ext * b_ext;
        m_reg    <= mult_reg;
        pout_reg <= {m_reg[MW-1], m_reg} + cin;
    end

    assign pout = pout_reg;
endmodule

module preadd_mac_seq #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int ADDSUB = 0,
    parameter int CNTW   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    preadd_mac_if.slave  bus
);
    localparam int MW     = AW + 1 + BW;
    localparam int STAGES = 6;

    typedef struct packed {
        logic          first;
        logic          last;
        logic [MW-1:0] bias;
    } flag_t;

    logic                 accept;
    logic                 accept_last;
    logic                 pop;
    logic                 capture;

    logic [1:0]           outstanding_reg;
    logic                 first_pending_reg;
    logic [CNTW-1:0]      term_cnt_reg;
    logic [CNTW-1:0]      beat_cnt;

    flag_t                flag_pipe_reg [0:STAGES-1];
    flag_t                stage_in;

    logic signed [AW-1:0] mac_a;
    logic signed [AW-1:0] mac_d;
    logic signed [BW-1:0] mac_b;
    logic signed [MW:0]   mac_cin;
    logic signed [MW:0]   mac_pout;

    logic [CNTW-1:0]      cq_mem_reg [0:1];
    logic                 cq_wr_reg;
    logic                 cq_rd_reg;

    logic signed [MW:0]   rf_data_reg  [0:1];
    logic [CNTW-1:0]      rf_terms_reg [0:1];
    logic                 rf_wr_reg;
    logic                 rf_rd_reg;
    logic [1:0]           rf_cnt_reg;

    // Limiting in-flight packets to two keeps both the count queue and result FIFO from overflowing
    assign bus.s_ready  = (outstanding_reg < 2'd2);
    assign accept       = bus.s_valid && bus.s_ready;
    assign accept_last  = accept && bus.s_last;
    assign pop          = bus.m_valid && bus.m_ready;
    assign capture      = flag_pipe_reg[STAGES-1].last;

    // Idle cycles feed zeros so the product contributes nothing to the running sum
    assign mac_a = accept ? bus.s_a : '0;
    assign mac_d = accept ? bus.s_d : '0;
    assign mac_b = accept ? bus.s_b : '0;

    // Restart with the bias exactly when the packet's first product sits in the MAC's m register
    assign mac_cin = flag_pipe_reg[4].first
                   ? {flag_pipe_reg[4].bias[MW-1], flag_pipe_reg[4].bias}
                   : mac_pout;

    cpreadder_mac_unit #(
        .AW     (AW),
        .BW     (BW),
        .ADDSUB (ADDSUB),
        .AREG   (2),
        .BREG   (3),
        .MW     (MW)
    ) u_mac (
        .clk  (clk),
        .ain  (mac_a),
        .din  (mac_d),
        .bin  (mac_b),
        .cin  (mac_cin),
        .pout (mac_pout)
    );

    always_comb begin
        beat_cnt = term_cnt_reg;
        if (first_pending_reg) begin
            beat_cnt = CNTW'(1);
        end else if (term_cnt_reg != {CNTW{1'b1}}) begin
            beat_cnt = term_cnt_reg + CNTW'(1);
        end
    end

    always_comb begin
        stage_in = '0;
        if (accept) begin
            stage_in.first = first_pending_reg;
            stage_in.last  = bus.s_last;
            stage_in.bias  = bus.s_bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                flag_pipe_reg[i] <= '0;
            end
        end else begin
            flag_pipe_reg[0] <= stage_in;
            for (int i = 1; i < STAGES; i++) begin
                flag_pipe_reg[i] <= flag_pipe_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_pending_reg <= 1'b1;
            term_cnt_reg      <= '0;
        end else if (accept) begin
            first_pending_reg <= bus.s_last;
            term_cnt_reg      <= beat_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= 2'd0;
        end else begin
            case ({accept_last, pop})
                2'b10:   outstanding_reg <= outstanding_reg + 2'd1;
                2'b01:   outstanding_reg <= outstanding_reg - 2'd1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Final term counts wait here until their sums leave the MAC pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq_mem_reg[0] <= '0;
            cq_mem_reg[1] <= '0;
            cq_wr_reg     <= 1'b0;
            cq_rd_reg     <= 1'b0;
        end else begin
            if (accept_last) begin
                cq_mem_reg[cq_wr_reg] <= beat_cnt;
                cq_wr_reg             <= ~cq_wr_reg;
            end
            if (capture) begin
                cq_rd_reg <= ~cq_rd_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rf_data_reg[i]  <= '0;
                rf_terms_reg[i] <= '0;
            end
            rf_wr_reg  <= 1'b0;
            rf_rd_reg  <= 1'b0;
            rf_cnt_reg <= 2'd0;
        end else begin
            if (capture) begin
                rf_data_reg[rf_wr_reg]  <= mac_pout;
                rf_terms_reg[rf_wr_reg] <= cq_mem_reg[cq_rd_reg];
                rf_wr_reg               <= ~rf_wr_reg;
            end
            if (pop) begin
                rf_rd_reg <= ~rf_rd_reg;
            end
            case ({capture, pop})
                2'b10:   rf_cnt_reg <= rf_cnt_reg + 2'd1;
                2'b01:   rf_cnt_reg <= rf_cnt_reg - 2'd1;
                default: rf_cnt_reg <= rf_cnt_reg;
            endcase
        end
    end

    assign bus.m_valid = (rf_cnt_reg != 2'd0);
    assign bus.m_data  = rf_data_reg[rf_rd_reg];
    assign bus.m_terms = rf_terms_reg[rf_rd_reg];
endmodule

// File: tb/tb_preadd_mac_seq.sv
// Scoreboard bench for preadd_mac_seq: a reference accumulator queues expected packet results
// as terms are accepted; a monitor pops and compares them as results are consumed.
module tb_preadd_mac_seq;
    localparam int AW   = 18;
    localparam int BW   = 18;
    localparam int CNTW = 8;
    localparam int MW   = AW + 1 + BW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    preadd_mac_if #(.AW(AW), .BW(BW), .CNTW(CNTW)) bus ();
    preadd_mac_if #(.AW(AW), .BW(BW), .CNTW(CNTW)) sub_bus ();
    preadd_mac_if #(.AW(AW), .BW(BW), .CNTW(2))    sat_bus ();

    preadd_mac_seq #(.AW(AW), .BW(BW), .ADDSUB(0), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    preadd_mac_seq #(.AW(AW), .BW(BW), .ADDSUB(1), .CNTW(CNTW)) dut_sub (
        .clk(clk), .rst_n(rst_n), .bus(sub_bus)
    );
    preadd_mac_seq #(.AW(AW), .BW(BW), .ADDSUB(0), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sat_bus)
    );

    typedef struct {
        longint data;
        longint terms;
    } exp_t;

    exp_t   exp_q[$];
    int     pop_cyc[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     sub_seen = 0;
    int     sat_seen = 0;

    longint model_acc   = 0;
    longint model_terms = 0;
    bit     model_first = 1'b1;
    exp_t   mon_e;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input longint a, input longint d, input longint b,
                        input bit last, input longint bias);
        int t;
        bus.s_a    = a[AW-1:0];
        bus.s_d    = d[AW-1:0];
        bus.s_b    = b[BW-1:0];
        bus.s_last = last;
        bus.s_bias = bias[MW-1:0];
        bus.s_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 500) begin
                check_val("s_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        if (model_first) begin
            model_acc   = bias;
            model_terms = 0;
        end
        model_acc   = model_acc + (a + d) * b;
        model_terms = (model_terms < 255) ? model_terms + 1 : 255;
        model_first = last;
        $display("beat   a=%0d d=%0d b=%0d last=%0b bias=%0d (cycle %0d)", a, d, b, last, bias, cyc);
        if (last) exp_q.push_back('{model_acc, model_terms});
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check_val("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_m_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("m_data", $signed(bus.m_data), mon_e.data);
                check_val("m_terms", bus.m_terms, mon_e.terms);
            end
            pop_cyc.push_back(cyc);
            $display("result data=%0d terms=%0d (cycle %0d)", $signed(bus.m_data), bus.m_terms, cyc);
        end
    end

    always @(negedge clk) begin
        if (sub_bus.m_valid && sub_bus.m_ready) begin
            sub_seen++;
            check_val("addsub1_data", $signed(sub_bus.m_data), 8);
            check_val("addsub1_terms", sub_bus.m_terms, 2);
            $display("result addsub1 data=%0d terms=%0d", $signed(sub_bus.m_data), sub_bus.m_terms);
        end
        if (sat_bus.m_valid && sat_bus.m_ready) begin
            sat_seen++;
            check_val("sat_data", $signed(sat_bus.m_data), 15);
            check_val("sat_terms", sat_bus.m_terms, 3);
            $display("result cntw2 data=%0d terms=%0d", $signed(sat_bus.m_data), sat_bus.m_terms);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        longint held;

        bus.s_valid = 0; bus.s_a = '0; bus.s_d = '0; bus.s_b = '0;
        bus.s_last = 0; bus.s_bias = '0; bus.m_ready = 1;
        sub_bus.s_valid = 0; sub_bus.s_a = '0; sub_bus.s_d = '0; sub_bus.s_b = '0;
        sub_bus.s_last = 0; sub_bus.s_bias = '0; sub_bus.m_ready = 1;
        sat_bus.s_valid = 0; sat_bus.s_a = '0; sat_bus.s_d = '0; sat_bus.s_b = '0;
        sat_bus.s_last = 0; sat_bus.s_bias = '0; sat_bus.m_ready = 1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_s_ready", bus.s_ready, 1);
        check_val("reset_m_valid", bus.m_valid, 0);
        check_val("reset_m_data", $signed(bus.m_data), 0);
        check_val("reset_m_terms", bus.m_terms, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDSUB=1 and CNTW=2 builds, driven together
        for (int i = 0; i < 5; i++) begin
            sub_bus.s_valid = (i < 2);
            sub_bus.s_a     = (i == 0) ? 18'sd10 : 18'sd3;
            sub_bus.s_d     = (i == 0) ? 18'sd4  : 18'sd5;
            sub_bus.s_b     = 18'sd2;
            sub_bus.s_last  = (i == 1);
            sat_bus.s_valid = 1'b1;
            sat_bus.s_a     = 18'(i + 1);
            sat_bus.s_d     = '0;
            sat_bus.s_b     = 18'sd1;
            sat_bus.s_last  = (i == 4);
            @(posedge clk);
            #1;
        end
        sub_bus.s_valid = 1'b0;
        sat_bus.s_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_val("addsub1_seen", sub_seen, 1);
        check_val("sat_seen", sat_seen, 1);

        // Basic 3-term packet with latency probe
        send(1, 4, 2, 0, 10);
        send(2, 5, -1, 0, 0);
        send(3, 6, 3, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) check_val("latency_e5_m_valid", bus.m_valid, 0);
            if (k == 6) begin
                check_val("latency_e6_m_valid", bus.m_valid, 1);
                check_val("basic_sum", $signed(bus.m_data), 40);
            end
        end
        drain();

        // Back-to-back single-term packets
        n0 = pop_cyc.size();
        send(-5, 2, 7, 1, 0);
        send(100, -100, 9, 1, -3);
        send(1, 1, 1, 1, 1);
        drain();
        if (pop_cyc.size() >= n0 + 2)
            check_val("b2b_consecutive", pop_cyc[n0+1] - pop_cyc[n0], 1);
        else
            check_val("b2b_result_count", pop_cyc.size() - n0, 3);

        // Bubbles between terms
        send(1, 4, 2, 0, 10);
        repeat (4) @(posedge clk);
        #1;
        send(2, 5, -1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        send(3, 6, 3, 1, 0);
        drain();

        // Backpressure
        bus.m_ready = 1'b0;
        send(7, 1, 2, 1, 0);
        send(-3, -4, 5, 1, 2);
        check_val("bp_s_ready_drop", bus.s_ready, 0);
        fork
            send(9, 9, -1, 1, 100);
            begin
                repeat (10) @(posedge clk);
                #1;
                check_val("bp_stall_s_ready", bus.s_ready, 0);
                check_val("bp_m_valid", bus.m_valid, 1);
                held = $signed(bus.m_data);
                @(posedge clk);
                #1;
                check_val("bp_hold_m_data", $signed(bus.m_data), held);
                bus.m_ready = 1'b1;
                @(posedge clk);
                #1;
                check_val("bp_release_s_ready", bus.s_ready, 1);
            end
        join
        drain();

        // Reset in the middle of a packet
        send(5, 5, 5, 0, 7);
        send(1, 2, 3, 0, 0);
        rst_n = 1'b0;
        model_first = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_m_valid", bus.m_valid, 0);
        check_val("midrst_s_ready", bus.s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1, 1, 1, 0, 0);
        send(1, 1, 1, 0, 0);
        send(1, 1, 1, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
        end
        check_val("midrst_sum", $signed(bus.m_data), 6);
        drain();
        repeat (20) @(posedge clk);
        #1;
        check_val("final_m_valid_idle", bus.m_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
